e_mdu: RTL

Execute-stage multiply/divide unit for the five-stage MIPS pipeline. It sits beside the ALU, downstream of the D/E pipeline register, and consumes that register's forwarded operand outputs (rs value, rt value) plus a decoded MD opcode. It computes multi-cycle MULT/MULTU/DIV/DIVU into private HI/LO registers. It also services MFHI/MFLO/MTHI/MTLO and exposes a `busy` flag that the hazard unit uses to stall MD-class instructions in D.

---
 rtl/e_mdu.sv | 120 ++++++++++++
 1 files changed

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - execute-stage multiply/divide unit with private HI/LO and a busy flag
// Optional MDU_MADD_EN enables MADD/MADDU accumulate into {HI,LO}.
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] md_out,
   output logic [31:0] HI,
   output logic [31:0] LO
);
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;
   localparam logic [3:0] OP_MADD  = 4'd9;
   localparam logic [3:0] OP_MADDU = 4'd10;
   localparam logic [3:0] MULT_N   = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_N    = 4'(DIV_CYCLES);

   typedef enum logic {IDLE, RUN} state_t;
   state_t state, next_state;

   logic [3:0]  count;
   logic [63:0] pend;
   logic        pend_wr, pend_acc;
   logic        is_mul, is_div, is_madd, accept, commit;

   always_comb begin
      is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
      is_div = (md_op == OP_DIV)  || (md_op == OP_DIVU);
`ifdef MDU_MADD_EN
      is_madd = (md_op == OP_MADD) || (md_op == OP_MADDU);
`else
      is_madd = 1'b0;
`endif
   end

   assign accept = start && (state == IDLE) && (is_mul || is_div || is_madd);
   assign commit = (state == RUN) && (count == 4'd1);
   assign busy   = (state == RUN);

   // Products: sign-extend for signed ops, keep the low 64 bits.
   logic [63:0] prod_s, prod_u;
   assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign prod_u = {32'd0, A} * {32'd0, B};

   // Divide on magnitudes, then restore signs; handles 0x80000000 / -1 without overflow.
   logic        sdiv;
   logic [31:0] dvd, dvs, dvs_safe, q_mag, r_mag, quo, rem;
   always_comb begin
      sdiv     = (md_op == OP_DIV);
      dvd      = (sdiv && A[31]) ? -A : A;
      dvs      = (sdiv && B[31]) ? -B : B;
      dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
      q_mag    = dvd / dvs_safe;
      r_mag    = dvd % dvs_safe;
      quo      = (sdiv && (A[31] ^ B[31])) ? -q_mag : q_mag;
      rem      = (sdiv && A[31]) ? -r_mag : r_mag;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = RUN;
         RUN:     if (count == 4'd1) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count    <= 4'd0;
         pend     <= 64'd0;
         pend_wr  <= 1'b0;
         pend_acc <= 1'b0;
         HI       <= 32'd0;
         LO       <= 32'd0;
      end else if (accept) begin
         count    <= is_div ? DIV_N : MULT_N;
         pend_wr  <= !(is_div && (B == 32'd0));
         pend_acc <= is_madd;
         case (md_op)
            OP_MULT, OP_MADD:   pend <= prod_s;
            OP_MULTU, OP_MADDU: pend <= prod_u;
            default:            pend <= {rem, quo};
         endcase
      end else if (state == RUN) begin
         count <= count - 4'd1;
         if (commit && pend_wr) begin
            if (pend_acc) {HI, LO} <= {HI, LO} + pend;
            else          {HI, LO} <= pend;
         end
      end else if (start) begin
         if (md_op == OP_MTHI) HI <= A;
         if (md_op == OP_MTLO) LO <= A;
      end
   end

   always_comb begin
      md_out = 32'd0;
      if (md_op == OP_MFHI) md_out = HI;
      if (md_op == OP_MFLO) md_out = LO;
   end
endmodule
